// File: rtl/fir_mac_fp16.sv
// fir_mac_fp16: streaming serial-MAC FIR filter with an FP16 result.
// The engine takes one signed Q1.(DW-1) sample per in_valid/in_ready handshake.
// It accumulates TAPS products against a writable coefficient bank and a circular
// delay line, then returns the sum as IEEE-754 half precision.
// Handshakes: a transfer happens on any rising clk edge where valid and ready are both
// high; valid never waits on ready, and out_fp/out_valid hold until out_ready.
// Optional build macro FIR_FP_RNE_EN: round-to-nearest-even mantissa (default truncates).
module fir_mac_fp16 #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int TAPS = 64,
    parameter int AW   = $clog2(TAPS),
    parameter int ACCW = DW + CW + AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_wdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_fp,
    output logic          busy,
    output logic [1:0]    state_dbg
);

    // Fractional bits of the accumulator and width of the normalisation window
    localparam int F  = (DW - 1) + (CW - 1);
    localparam int NW = ACCW + 12;

    typedef enum logic [1:0] {IDLE, MAC, CONV, OUT} state_t;

    state_t                   state;
    logic signed [DW-1:0]     x_mem [TAPS];
    logic signed [CW-1:0]     c_mem [TAPS];
    logic        [AW-1:0]     wr_ptr;
    logic        [AW-1:0]     newest_ptr;
    logic        [AW-1:0]     k;
    logic signed [ACCW-1:0]   acc;

    int                       rd_diff;
    logic        [AW-1:0]     rd_idx;
    logic signed [DW-1:0]     x_rd;
    logic signed [CW-1:0]     c_rd;
    logic signed [DW+CW-1:0]  prod;

    logic                     acc_sign;
    logic        [ACCW-1:0]   mag;
    int                       lead;
    logic        [NW-1:0]     norm;
    logic        [9:0]        mant;
    logic                     rnd;
    logic        [10:0]       mant_r;
    int                       e_pre;
    int                       e_post;
    logic        [15:0]       fp_next;
`ifdef FIR_FP_RNE_EN
    logic                     guard_bit;
    logic                     sticky_bit;
`endif

    assign in_ready  = reset_n && (state == IDLE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Delay-line read address (newest - k) mod TAPS and the signed product for this tap
    always_comb begin
        rd_diff = int'(newest_ptr) - int'(k);
        if (rd_diff < 0) rd_diff = rd_diff + TAPS;
        rd_idx = AW'(rd_diff);
        x_rd   = x_mem[rd_idx];
        c_rd   = c_mem[k];
        prod   = (DW+CW)'(x_rd) * (DW+CW)'(c_rd);
    end

    // Accumulator to FP16: normalise magnitude, truncate or round mantissa, clamp exponent
    always_comb begin
        acc_sign = acc[ACCW-1];
        mag      = acc_sign ? $unsigned(-acc) : $unsigned(acc);
        lead     = 0;
        for (int i = 0; i < ACCW; i++) begin
            if (mag[i]) lead = i;
        end
        norm  = {mag, 12'h000} << (ACCW - 1 - lead);
        mant  = 10'(norm >> (NW - 11));
`ifdef FIR_FP_RNE_EN
        guard_bit  = norm[NW-12];
        sticky_bit = |norm[NW-13:0];
        rnd        = guard_bit & (sticky_bit | mant[0]);
`else
        rnd = 1'b0;
`endif
        e_pre   = lead - F + 15;
        mant_r  = {1'b0, mant} + {10'h000, rnd};
        e_post  = e_pre + int'(mant_r[10]);
        fp_next = 16'h0000;
        if (mag == '0) begin
            fp_next = 16'h0000;
        end else if (e_pre <= 0) begin
            fp_next = {acc_sign, 15'h0000};
        end else if (e_post >= 31) begin
            fp_next = {acc_sign, 5'd30, 10'h3FF};
        end else begin
            fp_next = {acc_sign, 5'(e_post), mant_r[9:0]};
        end
    end

    // Control FSM with the delay line, accumulator and registered result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            newest_ptr <= '0;
            k          <= '0;
            acc        <= '0;
            out_fp     <= 16'h0000;
            out_valid  <= 1'b0;
            for (int i = 0; i < TAPS; i++) x_mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        x_mem[wr_ptr] <= in_data;
                        newest_ptr    <= wr_ptr;
                        wr_ptr        <= (wr_ptr == AW'(TAPS - 1)) ? '0 : wr_ptr + AW'(1);
                        acc           <= '0;
                        k             <= '0;
                        state         <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACCW'(prod);
                    if (k == AW'(TAPS - 1)) state <= CONV;
                    else                    k     <= k + AW'(1);
                end
                CONV: begin
                    out_fp    <= fp_next;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Coefficient bank: writable only while idle, so a MAC pass never sees a torn bank
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) c_mem[i] <= '0;
        end else if (coef_we && (state == IDLE) && (int'(coef_addr) < TAPS)) begin
            c_mem[coef_addr] <= coef_wdata;
        end
    end

endmodule

// File: tb/tb_fir_mac_fp16.sv
// tb_fir_mac_fp16: directed and randomized checks of fir_mac_fp16 against a
// behavioural FIR/FP16 model. Build with FIR_FP_RNE_EN to check the rounding variant.
module tb_fir_mac_fp16;

    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int TAPS = 64;
    localparam int AW   = $clog2(TAPS);
    localparam int FR   = (DW - 1) + (CW - 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [CW-1:0] coef_wdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   out_fp;
    logic          busy;
    logic [1:0]    state_dbg;

    fir_mac_fp16 #(.DW(DW), .CW(CW), .TAPS(TAPS)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    int          hs_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          inflight = 1'b0;
    bit          seen_valid = 1'b0;
    int          ready_mode = 1;   // 0 random, 1 high, 2 low

    logic signed [DW-1:0] m_hist [TAPS];
    logic signed [CW-1:0] m_coef [TAPS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] to_fp16(input longint s);
        logic   sg;
        longint mag, pw, num, q;
        int     e, bexp;
        if (s == 0) return 16'h0000;
        sg  = (s < 0);
        mag = sg ? -s : s;
        e   = 0;
        while ((longint'(1) << (e + 1)) <= mag) e++;
        bexp = e - FR + 15;
        if (bexp <= 0) return {sg, 15'h0000};
        pw  = longint'(1) << e;
        num = mag * 1024;
        q   = num / pw;
`ifdef FIR_FP_RNE_EN
        begin
            longint r;
            r = num % pw;
            if ((2 * r > pw) || ((2 * r == pw) && (q % 2 == 1))) q++;
        end
`endif
        if (q >= 2048) begin
            q = q / 2;
            bexp++;
        end
        if (bexp >= 31) return {sg, 15'h7BFF};
        return {sg, 5'(bexp), 10'(q - 1024)};
    endfunction

    function automatic logic [15:0] model_out();
        longint s = 0;
        for (int i = 0; i < TAPS; i++) s += longint'(m_hist[i]) * longint'(m_coef[i]);
        return to_fp16(s);
    endfunction

    function automatic void model_push(input logic [DW-1:0] d);
        for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = d;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < TAPS; i++) begin
            m_hist[i] = '0;
            m_coef[i] = '0;
        end
    endfunction

    // ---------------- out_ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = (ready_mode == 1) ? 1'b1 :
                        (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_out_valid");
                end else begin
                    if (!seen_valid) begin
                        chk("latency", 32'(cyc - hs_q[0]), TAPS + 1);
                        seen_valid = 1'b1;
                    end
                    chk("out_fp", {16'h0, out_fp}, {16'h0, exp_q[0]});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(hs_q.pop_front());
                        seen_valid = 1'b0;
                        inflight   = 1'b0;
                    end
                end
            end else if (seen_valid) begin
                fail_now("out_valid_dropped");
                seen_valid = 1'b0;
            end
            if (inflight && !out_valid) begin
                chk("in_ready_low", {31'h0, in_ready}, 0);
                chk("busy_high", {31'h0, busy}, 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        reset_n  = 1'b0;
        exp_q.delete();
        hs_q.delete();
        inflight   = 1'b0;
        seen_valid = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 0);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'h0, in_ready}, 1);
        chk("post_rst_out_valid", {31'h0, out_valid}, 0);
        chk("post_rst_out_fp", {16'h0, out_fp}, 0);
        chk("post_rst_busy", {31'h0, busy}, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) fail_now("wait_idle_timeout");
    endtask

    task automatic set_coef(input int addr, input logic [CW-1:0] val);
        wait_idle();
        coef_we    = 1'b1;
        coef_addr  = AW'(addr);
        coef_wdata = val;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        m_coef[addr] = val;
    endtask

    // use_const: push the given constant instead of the model prediction
    task automatic send(input logic [DW-1:0] d, input bit use_const, input logic [15:0] cval);
        int waited = 0;
        bit acc_now;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (waited < 500) begin
            @(negedge clk);
            acc_now = in_ready;
            @(posedge clk);
            #1;
            if (acc_now) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            fail_now("in_ready_timeout");
        end else begin
            model_push(d);
            exp_q.push_back(use_const ? cval : model_out());
            hs_q.push_back(cyc);
            inflight = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        model_clear();
        ready_mode = 1;
        do_reset();

        // untouched coefficients give zero
        send(16'h4000, 1'b1, 16'h0000);
        // half times just-under-one
        set_coef(0, 16'h4000);
`ifdef FIR_FP_RNE_EN
        send(16'h7FFF, 1'b1, 16'h3800);
`else
        send(16'h7FFF, 1'b1, 16'h37FF);
`endif

        // delayed tap: impulse appears three samples later
        do_reset();
        set_coef(3, 16'h4000);
        send(16'h4000, 1'b1, 16'h0000);
        send(16'h0000, 1'b1, 16'h0000);
        send(16'h0000, 1'b1, 16'h0000);
        send(16'h0000, 1'b1, 16'h3400);

        // -1 * -1, then full bank of -1 across a delay-line wrap
        do_reset();
        set_coef(0, 16'h8000);
        send(16'h8000, 1'b1, 16'h3C00);
        for (int i = 1; i < TAPS; i++) set_coef(i, 16'h8000);
        for (int i = 0; i < TAPS - 1; i++) send(16'h8000, 1'b0, 16'h0000);
        send(16'h8000, 1'b1, 16'h5400);

        // tiny results: flush to signed zero and smallest normal
        do_reset();
        set_coef(0, 16'h0001);
        send(16'h0001, 1'b1, 16'h0000);
        send(16'hFFFF, 1'b1, 16'h8000);
        send(16'h8000, 1'b1, 16'h8000);
        set_coef(0, 16'h0002);
        send(16'h8000, 1'b1, 16'h8400);

        // result held under back-pressure; in_valid and coef_we ignored while busy
        do_reset();
        set_coef(0, 16'h4000);
        set_coef(1, 16'h2000);
        ready_mode = 2;
        send(16'h2000, 1'b0, 16'h0000);
        coef_we = 1'b1; coef_addr = 0; coef_wdata = 16'h7FFF;
        @(posedge clk); #1;
        coef_addr = 1;
        @(posedge clk); #1;
        coef_we = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("out_valid_timeout");
        in_valid = 1'b1; in_data = 16'h1234;
        coef_we = 1'b1; coef_addr = 0; coef_wdata = 16'h1111;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        ready_mode = 1;
        send(16'h4000, 1'b0, 16'h0000);

        // reset in the middle of a MAC pass discards everything
        do_reset();
        set_coef(0, 16'h4000);
        set_coef(1, 16'h4000);
        send(16'h4000, 1'b0, 16'h0000);
        repeat (20) @(posedge clk);
        #1;
        do_reset();
        set_coef(0, 16'h4000);
        set_coef(1, 16'h4000);
        send(16'h4000, 1'b1, 16'h3400);

        // randomized coefficients, samples and back-pressure
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < TAPS; i++) set_coef(i, CW'($urandom));
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) set_coef($urandom_range(0, TAPS - 1), CW'($urandom));
            if ($urandom_range(0, 5) == 0) send(DW'($urandom_range(0, 15)), 1'b0, 16'h0000);
            else                           send(DW'($urandom), 1'b0, 16'h0000);
        end
        wait_idle();
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // watchdog
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule
